control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Moore FSM sequencing the serial port-demultiplexer data path. Sits directly upstream of
//  data_path: consumes SerIn and the datapath carry-outs (co1, co2, coD); drives its shift,
//  count and load enables. Frame on SerIn: start bit (0), 2 port bits, 5 length bits, LEN payload bits.
// PARAMETERS
//  FRAME_CNT_W  8  width of completed-frame counter output (wraps)
// PORTS
//  clk        in   1  system clock, all state updates on rising edge
//  reset      in   1  asynchronous, active-low reset (0 = reset)
//  clkEN      in   1  step strobe; FSM and counters advance only on edges with clkEN=1
//  SerIn      in   1  serial line, idle high
//  co1        in   1  port-bit counter carry: current port bit is the last one
//  co2        in   1  length-bit counter carry: current length bit is the last one
//  coD        in   1  payload down-counter at zero
//  sh_en      out  1  shift enable, port-number shift register
//  sh_enD     out  1  shift enable, length shift register
//  cnt1       out  1  count enable, port-bit counter
//  cnt2       out  1  count enable, length-bit counter
//  ld_cntD    out  1  load payload down-counter from length register
//  cntD       out  1  count enable, payload down-counter
//  valid      out  1  payload bit on SerIn is being routed to P
//  done       out  1  one clkEN-qualified cycle pulse, frame complete
//  err        out  1  sticky framing error (STOP_CHECK_EN only, else tied 0)
//  frame_cnt  out  FRAME_CNT_W  completed frames, wraps at 2^FRAME_CNT_W
//  state_dbg  out  3  current state encoding
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, frame_cnt=0, err=0; all enables, valid, done = 0.
//  - Transitions only at rising clk with clkEN=1; clkEN=0 holds state, outputs unchanged.
//  - Outputs are decoded from state only (plus coD for XMIT); no input-to-output path otherwise.
//  - States / encoding: IDLE=0, GET_PORT=1, GET_LEN=2, LOAD=3, XMIT=4, STOP=5, DONE=6.
//  - IDLE: all enables 0. SerIn=0 -> GET_PORT (start bit consumed, not shifted).
//  - GET_PORT: sh_en=1, cnt1=1. co1=1 -> GET_LEN, else stay. Exactly 2 enabled cycles.
//  - GET_LEN: sh_enD=1, cnt2=1. co2=1 -> LOAD, else stay. Exactly 5 enabled cycles.
//  - LOAD: ld_cntD=1 for one enabled cycle -> XMIT. SerIn ignored here.
//  - XMIT: cntD=~coD, valid=~coD. coD=1 -> STOP (macro) or DONE. LEN payload bits pass;
//    LEN=0 gives zero payload cycles (valid never rises, exits on first enabled cycle).
//  - DONE: done=1 one enabled cycle; frame_cnt+1 (mod 2^FRAME_CNT_W) -> IDLE.
//  - Back-to-back: start bit only sampled in IDLE; a 0 on SerIn during DONE is ignored.
//  - Only one enable among sh_en/sh_enD/ld_cntD/cntD active in any state (mutually exclusive).
//  - Reset mid-frame: immediate return to IDLE, partial frame discarded, no done pulse.
//  - Illegal state_dbg codes (7) -> IDLE on next enabled edge, outputs as IDLE.
// CONFIGURATION
//  STOP_CHECK_EN defined: after XMIT enter STOP (all enables 0) for one enabled cycle,
//    sample SerIn: 1 -> DONE; 0 -> set err (sticky until reset), go IDLE, no done,
//    frame_cnt unchanged.
//  STOP_CHECK_EN undefined: STOP unreachable, XMIT -> DONE directly, err constant 0.
// TESTING
//  1 reset=0 mid-GET_LEN, clkEN=1 -> state_dbg=0, all outputs 0 asynchronously, frame_cnt=0.
//  2 frame start,port=2'b10,len=5'b00011 -> sh_en 2 cyc, sh_enD 5 cyc, ld_cntD 1, valid 3, done 1.
//  3 len=0 frame -> valid never 1, done pulses 1 enabled cycle after LOAD+XMIT, frame_cnt+1.
//  4 clkEN low 4 cycles inside XMIT -> state/valid frozen, resumes; payload count still exact.
//  5 two frames back-to-back (start bit right after DONE) -> frame_cnt=2, no lost bits.
//  6 STOP_CHECK_EN, stop bit=0 -> err=1 held, no done, frame_cnt unchanged; next frame still runs.

Source files
------------

// File: rtl/control_unit.sv
// Moore sequencer for the serial port-demultiplexer datapath: start bit, 2 port bits, 5 length bits, LEN payload bits.
// Optional feature macro STOP_CHECK_EN: adds a STOP state that checks a trailing stop bit and sets a sticky err.
`timescale 1ns/1ps

module control_unit #(
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clkEN,
  input  logic                   SerIn,
  input  logic                   co1,
  input  logic                   co2,
  input  logic                   coD,
  output logic                   sh_en,
  output logic                   sh_enD,
  output logic                   cnt1,
  output logic                   cnt2,
  output logic                   ld_cntD,
  output logic                   cntD,
  output logic                   valid,
  output logic                   done,
  output logic                   err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_PORT = 3'd1,
    GET_LEN  = 3'd2,
    LOAD     = 3'd3,
    XMIT     = 3'd4,
    STOP     = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

`ifdef STOP_CHECK_EN
  logic err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (clkEN) begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
    end else if (clkEN) begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
`ifdef STOP_CHECK_EN
    err_d       = err_q;
`endif
    sh_en       = 1'b0;
    sh_enD      = 1'b0;
    cnt1        = 1'b0;
    cnt2        = 1'b0;
    ld_cntD     = 1'b0;
    cntD        = 1'b0;
    valid       = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        // The start bit only triggers the frame; it is never shifted into the datapath.
        if (!SerIn) state_d = GET_PORT;
      end
      GET_PORT: begin
        sh_en = 1'b1;
        cnt1  = 1'b1;
        if (co1) state_d = GET_LEN;
      end
      GET_LEN: begin
        sh_enD = 1'b1;
        cnt2   = 1'b1;
        if (co2) state_d = LOAD;
      end
      LOAD: begin
        ld_cntD = 1'b1;
        state_d = XMIT;
      end
      XMIT: begin
        // A zero length leaves coD set on entry, so the frame exits without routing a bit.
        cntD  = ~coD;
        valid = ~coD;
        if (coD) begin
`ifdef STOP_CHECK_EN
          state_d = STOP;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef STOP_CHECK_EN
      STOP: begin
        if (SerIn) begin
          state_d = DONE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      DONE: begin
        done        = 1'b1;
        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_cnt = frame_cnt_q;
  assign state_dbg = state_q;

endmodule
